fifo_rd_fwft: RTL and testbench

Single-clock FIFO read-side controller that drains the dual-port FIFO memory (`fifomem`) and presents its contents as a first-word-fall-through valid/ready stream. The block compares the writer's pointer against its own read pointer, issues memory reads ahead of demand, and absorbs the memory's 1- or 2-cycle read latency in a small output buffer, so a continuously ready consumer receives one word per clock. It sits between `fifomem` port B and the downstream ADC sample consumer. It returns its pointer to the writer for the full calculation.

---
 rtl/fifo_rd_fwft_pkg.sv | 18 +
 rtl/fifo_rd_fwft_if.sv | 11 +
 rtl/fifo_rd_fwft_skid_buf.sv | 55 +++++
 rtl/fifo_rd_fwft.sv | 82 ++++++++
 tb/tb_fifo_rd_fwft.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_rd_fwft_pkg.sv
// Shared constants for the FIFO read side: memory read latency, output buffer
// depth and pointer width, all derived from the fifomem configuration.
package fifo_rd_fwft_pkg;

  function automatic int unsigned rd_latency(input bit output_reg_en);
    return output_reg_en ? 32'd2 : 32'd1;
  endfunction

  // One slot per in-flight read plus one so a ready consumer never sees a bubble
  function automatic int unsigned skid_depth(input bit output_reg_en);
    return rd_latency(output_reg_en) + 32'd1;
  endfunction

  function automatic int unsigned ptr_width(input int unsigned nbit_a);
    return nbit_a + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_rd_fwft_if.sv
// First-word-fall-through output stream between the FIFO reader and its consumer.
interface fifo_rd_fwft_if #(
  parameter int unsigned p_nbit_d = 8
);
  logic [p_nbit_d-1:0] dout;
  logic                dout_valid;
  logic                dout_ready;

  modport master (output dout, output dout_valid, input dout_ready);
  modport slave  (input dout, input dout_valid, output dout_ready);
endinterface

// File: rtl/fifo_rd_fwft_skid_buf.sv
// Small register FIFO that absorbs memory read latency; head word is presented
// combinationally from the storage registers.
module fifo_skid_buf #(
  parameter  int unsigned p_depth = 3,
  parameter  int unsigned p_width = 8,
  localparam int unsigned cnt_w   = $clog2(p_depth + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               push,
  input  logic               pop,
  input  logic [p_width-1:0] din,
  output logic [p_width-1:0] dout,
  output logic               valid,
  output logic [cnt_w-1:0]   count
);
  localparam int unsigned idx_w = (p_depth > 1) ? $clog2(p_depth) : 1;

  logic [p_width-1:0] mem [p_depth];
  logic [idx_w-1:0]   wr_idx;
  logic [idx_w-1:0]   rd_idx;
  logic               pop_ok;

  function automatic logic [idx_w-1:0] next_idx(input logic [idx_w-1:0] idx);
    return (idx == idx_w'(p_depth - 1)) ? '0 : idx + idx_w'(1);
  endfunction

  assign pop_ok = pop && valid;

  // Push into the slot being popped is safe at full: the head is read before the edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '{default: '0};
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_idx] <= din;
        wr_idx      <= next_idx(wr_idx);
      end
      if (pop_ok) rd_idx <= next_idx(rd_idx);
      count <= count + cnt_w'(push) - cnt_w'(pop_ok);
    end
  end

  assign dout  = mem[rd_idx];
  assign valid = (count != '0);

endmodule

// File: rtl/fifo_rd_fwft.sv
// FIFO read-side controller: issues fifomem reads ahead of demand and presents
// the data as a first-word-fall-through stream with no bubbles.
module fifo_rd_fwft
  import fifo_rd_fwft_pkg::*;
#(
  parameter int unsigned p_nbit_d        = 8,
  parameter int unsigned p_nbit_a        = 4,
  parameter bit          p_output_reg_en = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic [p_nbit_a:0]   wptr,
  output logic [p_nbit_a:0]   rptr,
  output logic                rd,
  output logic [p_nbit_a-1:0] raddr,
  input  logic [p_nbit_d-1:0] rdata,
  fifo_rd_fwft_if.master      st,
  output logic                empty,
  output logic [p_nbit_a:0]   level
);
  localparam int unsigned lat   = rd_latency(p_output_reg_en);
  localparam int unsigned depth = skid_depth(p_output_reg_en);
  localparam int unsigned pw    = ptr_width(p_nbit_a);
  localparam int unsigned cnt_w = $clog2(depth + 1);
  localparam int unsigned sum_w = $clog2(2 * depth + 1) + 1;

  logic [pw-1:0]    iptr;
  logic [lat-1:0]   vld;
  logic [cnt_w-1:0] count;
  logic [sum_w-1:0] inflight;
  logic             pop;

  assign pop = st.dout_valid && st.dout_ready;

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < lat; i++) inflight = inflight + sum_w'(vld[i]);
  end

  // Reserve a buffer slot for every outstanding read; gated by reset so a
  // writer pointer held during reset does not trigger reads
  assign rd = rst_n && !flush && (iptr != wptr) &&
              ((sum_w'(count) + inflight) < (sum_w'(depth) + sum_w'(pop)));

  assign raddr = iptr[p_nbit_a-1:0];
  assign empty = !rst_n || (wptr == rptr);
  assign level = rst_n ? (wptr - rptr) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iptr <= '0;
      rptr <= '0;
      vld  <= '0;
    end else if (flush) begin
      iptr <= wptr;
      rptr <= wptr;
      vld  <= '0;
    end else begin
      if (rd)  iptr <= iptr + pw'(1);
      if (pop) rptr <= rptr + pw'(1);
      vld[0] <= rd;
      for (int unsigned i = 1; i < lat; i++) vld[i] <= vld[i-1];
    end
  end

  fifo_skid_buf #(
    .p_depth (depth),
    .p_width (p_nbit_d)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .push  (vld[lat-1]),
    .pop   (pop),
    .din   (rdata),
    .dout  (st.dout),
    .valid (st.dout_valid),
    .count (count)
  );

endmodule

// File: tb/tb_fifo_rd_fwft.sv
// Bench for fifo_rd_fwft: behavioural writer and fifomem, two readers (L=2 and
// L=1) checked against scoreboard queues and directed timing expectations.
module tb_fifo_rd_fwft;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  logic [AW:0]   wptr;
  logic [AW:0]   rptr0, rptr1, level0, level1;
  logic          rd0, rd1, empty0, empty1;
  logic [AW-1:0] raddr0, raddr1;
  logic [DW-1:0] rdata0, rdata1;

  fifo_rd_fwft_if #(.p_nbit_d(DW)) st0 ();
  fifo_rd_fwft_if #(.p_nbit_d(DW)) st1 ();

  fifo_rd_fwft #(.p_nbit_d(DW), .p_nbit_a(AW), .p_output_reg_en(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wptr(wptr), .rptr(rptr0),
    .rd(rd0), .raddr(raddr0), .rdata(rdata0), .st(st0), .empty(empty0), .level(level0));

  fifo_rd_fwft #(.p_nbit_d(DW), .p_nbit_a(AW), .p_output_reg_en(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .wptr(wptr), .rptr(rptr1),
    .rd(rd1), .raddr(raddr1), .rdata(rdata1), .st(st1), .empty(empty1), .level(level1));

  // fifomem model: shared write port, one read port per reader
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] m0_q = '0, m0_q2 = '0, m1_q = '0;
  always @(posedge clk) begin
    if (rd0) m0_q <= mem[raddr0];
    m0_q2 <= m0_q;
    if (rd1) m1_q <= mem[raddr1];
  end
  assign rdata0 = m0_q2;
  assign rdata1 = m1_q;

  // Behavioural writer; reset preloads five words so wptr=5 during reset
  logic          wr_en   = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          full;
  int            nwr = 0;
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  assign full = (5'(wptr - rptr0) == 5'd16);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) mem[i] <= 8'hA0 + 8'(i);
      wptr <= 5'd5;
    end else if (wr_en && !full) begin
      mem[wptr[AW-1:0]] <= wr_data;
      wptr <= wptr + 5'd1;
      q0.push_back(wr_data);
      q1.push_back(wr_data);
      nwr++;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor and independent read-pointer model
  logic [AW:0] rp_model   = '0;
  logic [AW:0] prev_rptr  = '0;
  logic        wrap_seen  = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (flush) begin
        q0.delete();
        rp_model = wptr;
      end else if (st0.dout_valid && st0.dout_ready) begin
        chk("pop0_expected", 32'(q0.size() != 0), 32'd1);
        if (q0.size() != 0) chk("dout0", 32'(st0.dout), 32'(q0.pop_front()));
        rp_model = rp_model + 5'd1;
      end
      if (st1.dout_valid && st1.dout_ready) begin
        chk("pop1_expected", 32'(q1.size() != 0), 32'd1);
        if (q1.size() != 0) chk("dout1", 32'(st1.dout), 32'(q1.pop_front()));
      end
      if (prev_rptr == 5'h1F && rptr0 == 5'h00) wrap_seen = 1'b1;
      prev_rptr = rptr0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic burst(input int n, input logic [DW-1:0] base);
    wr_en   = 1'b1;
    wr_data = base;
    for (int i = 0; i < n; i++) begin
      tick();
      wr_data = base + 8'(i + 1);
    end
    wr_en = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    st0.dout_ready = 1'b1;
    while (n < max_cycles && (q0.size() != 0 || st0.dout_valid)) begin
      tick();
      n++;
    end
    #1;
    chk("drain_queue", 32'(q0.size()), 32'd0);
    chk("drain_empty", 32'(empty0), 32'd1);
  endtask

  logic          held_stall = 1'b0;
  logic [DW-1:0] held       = '0;
  int            nwr_base   = 0;

  initial begin
    st0.dout_ready = 1'b0;
    st1.dout_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      q0.push_back(8'hA0 + 8'(i));
      q1.push_back(8'hA0 + 8'(i));
    end

    // Reset held for three cycles with wptr = 5
    repeat (3) tick();
    #1;
    chk("rst_rd",    32'(rd0), 32'd0);
    chk("rst_raddr", 32'(raddr0), 32'd0);
    chk("rst_rptr",  32'(rptr0), 32'd0);
    chk("rst_dout",  32'(st0.dout), 32'd0);
    chk("rst_valid", 32'(st0.dout_valid), 32'd0);
    chk("rst_empty", 32'(empty0), 32'd1);
    chk("rst_level", 32'(level0), 32'd0);
    chk("rst_rd1",   32'(rd1), 32'd0);

    rst_n = 1'b1;
    st0.dout_ready = 1'b1;
    #1;
    chk("rel_rd",    32'(rd0), 32'd1);
    chk("rel_raddr", 32'(raddr0), 32'd0);
    chk("rel_level", 32'(level0), 32'd5);
    chk("rel_empty", 32'(empty0), 32'd0);
    for (int k = 1; k < 10; k++) begin
      tick();
      #1;
      chk("rel_valid0", 32'(st0.dout_valid), 32'(k >= 3 && k <= 7));
      chk("rel_valid1", 32'(st1.dout_valid), 32'(k >= 2 && k <= 6));
    end
    chk("rel_rptr",   32'(rptr0), 32'd5);
    chk("rel_empty2", 32'(empty0), 32'd1);

    // Streaming 0x00..0x0F: latency 3 (L=2) and 2 (L=1), then no bubbles
    wr_en   = 1'b1;
    wr_data = 8'h00;
    for (int k = 0; k <= 20; k++) begin
      tick();
      if (k < 15) wr_data = 8'(k + 1);
      else        wr_en   = 1'b0;
      #1;
      if (k == 0) chk("stream_rd", 32'(rd0), 32'd1);
      chk("stream_valid0", 32'(st0.dout_valid), 32'(k >= 3 && k <= 18));
      if (k >= 3 && k <= 18) chk("stream_seq0", 32'(st0.dout), 32'(k - 3));
      chk("stream_valid1", 32'(st1.dout_valid), 32'(k >= 2 && k <= 17));
    end
    chk("stream_empty", 32'(empty0), 32'd1);

    // Backpressure: eight stored words, reads stop once buffer and pipe are full
    st0.dout_ready = 1'b0;
    burst(8, 8'h40);
    repeat (6) tick();
    #1;
    chk("bp_valid", 32'(st0.dout_valid), 32'd1);
    chk("bp_dout",  32'(st0.dout), 32'h40);
    chk("bp_rd",    32'(rd0), 32'd0);
    chk("bp_raddr", 32'(raddr0), 32'(4'(rp_model + 5'd3)));
    chk("bp_level", 32'(level0), 32'd8);
    chk("bp_rptr",  32'(rptr0), 32'(rp_model));
    held_stall = 1'b1;
    held       = st0.dout;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (held_stall) chk("bp_hold", 32'(st0.dout), 32'(held));
      st0.dout_ready = 1'($urandom_range(0, 1));
      #1;
      held_stall = st0.dout_valid && !st0.dout_ready;
      held       = st0.dout;
    end
    drain(100);

    // Wrap: 40 words through the 16-deep FIFO
    burst(40, 8'h10);
    drain(100);
    chk("wrap_seen",  32'(wrap_seen), 32'd1);
    chk("wrap_rptr",  32'(rptr0), 32'(rp_model));
    chk("wrap_level", 32'(level0), 32'd0);

    // Full: consumer stalled, writer stops at 16
    st0.dout_ready = 1'b0;
    nwr_base = nwr;
    burst(18, 8'h80);
    repeat (4) tick();
    #1;
    chk("full_writes", 32'(nwr - nwr_base), 32'd16);
    chk("full_level",  32'(level0), 32'd16);
    chk("full_wptr",   32'(wptr), 32'(5'(rp_model + 5'd16)));
    chk("full_rptr",   32'(rptr0), 32'(rp_model));
    chk("full_dout",   32'(st0.dout), 32'h80);
    st0.dout_ready = 1'b1;
    tick();
    st0.dout_ready = 1'b0;
    #1;
    chk("full_pop_level", 32'(level0), 32'd15);
    chk("full_pop_rptr",  32'(rptr0), 32'(rp_model));
    wr_en   = 1'b1;
    wr_data = 8'h90;
    tick();
    wr_en = 1'b0;
    #1;
    chk("full_rewrite", 32'(nwr - nwr_base), 32'd17);
    chk("full_level2",  32'(level0), 32'd16);
    drain(100);

    // Flush with two reads in flight and one word buffered
    st0.dout_ready = 1'b0;
    wr_en   = 1'b1;
    wr_data = 8'hC0;
    tick(); wr_data = 8'hC1;
    tick(); wr_data = 8'hC2;
    tick(); wr_data = 8'hC3;
    tick(); wr_en   = 1'b0;
    #1;
    chk("pre_flush_rd",    32'(rd0), 32'd0);
    chk("pre_flush_valid", 32'(st0.dout_valid), 32'd1);
    chk("pre_flush_dout",  32'(st0.dout), 32'hC0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("flush_valid", 32'(st0.dout_valid), 32'd0);
    chk("flush_rptr",  32'(rptr0), 32'(wptr));
    chk("flush_raddr", 32'(raddr0), 32'(wptr[AW-1:0]));
    chk("flush_level", 32'(level0), 32'd0);
    chk("flush_empty", 32'(empty0), 32'd1);
    chk("flush_rd",    32'(rd0), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      chk("flush_stale", 32'(st0.dout_valid), 32'd0);
    end
    st0.dout_ready = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'hC5;
    tick();
    wr_en = 1'b0;
    #1;
    chk("post_flush_rd", 32'(rd0), 32'd1);
    tick();
    tick();
    #1;
    chk("post_flush_lat", 32'(st0.dout_valid), 32'd0);
    tick();
    #1;
    chk("post_flush_valid", 32'(st0.dout_valid), 32'd1);
    chk("post_flush_dout",  32'(st0.dout), 32'hC5);
    drain(50);

    repeat (4) tick();
    chk("l1_queue", 32'(q1.size()), 32'd0);
    chk("l1_empty", 32'(empty1), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
